sm_uart_rx: RTL and testbench

SM_UART_RX -- requirements
Module: sm_uart_rx

---
 rtl/sm_uart_pkg.sv | 30 +++
 rtl/sm_uart_baud_gen.sv | 29 ++
 rtl/sm_uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_sm_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sm_uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling constants and divider math.
// The PARITY state exists only when SM_UART_RX_PARITY_EN is defined.
package sm_uart_pkg;

  localparam int unsigned OSR    = 16;
  localparam int unsigned MID    = 8;
  localparam int unsigned TICK_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SM_UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // Rounded clocks per oversample tick, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    int unsigned den;
    int unsigned div;
    den = baud_rate * OSR;
    div = (clk_freq + den / 2) / den;
    if (div == 0) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/sm_uart_baud_gen.sv
// Oversample tick generator: one-clock tick every DIV clocks, realigned by restart.
module sm_uart_baud_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = w_wrap && !restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (restart || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sm_uart_rx.sv
// 16x oversampled UART receiver with valid/ready output and error pulses.
// Optional even parity bit enabled by macro SM_UART_RX_PARITY_EN.
module sm_uart_rx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  import sm_uart_pkg::*;

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);

  logic              r_sync1, r_sync2, r_prev;
  state_t            r_state, w_state_nxt;
  logic [TICK_W-1:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              w_tick, w_fall, w_restart, w_done, w_ferr, w_xfer;
`ifdef SM_UART_RX_PARITY_EN
  logic              r_par_bad, w_par_bad_nxt, w_perr;
`endif

  sm_uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign w_fall = r_prev && !r_sync2;
  assign w_xfer = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_prev     <= 1'b1;
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
`ifdef SM_UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
`endif
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
`ifdef SM_UART_RX_PARITY_EN
      r_par_bad  <= w_par_bad_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_restart      = 1'b0;
    w_done         = 1'b0;
    w_ferr         = 1'b0;
`ifdef SM_UART_RX_PARITY_EN
    w_par_bad_nxt  = r_par_bad;
    w_perr         = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt    = ST_START;
          w_restart      = 1'b1;
          w_tick_cnt_nxt = '0;
          w_bit_cnt_nxt  = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_tick_cnt == TICK_W'(MID - 1)) begin
            w_tick_cnt_nxt = '0;
            w_state_nxt    = r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == TICK_W'(OSR - 1)) begin
            w_tick_cnt_nxt = '0;
            w_shift_nxt    = {r_sync2, r_shift[7:1]};
            w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef SM_UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 4'd1;
          end
        end
      end
`ifdef SM_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          if (r_tick_cnt == TICK_W'(OSR - 1)) begin
            w_tick_cnt_nxt = '0;
            w_par_bad_nxt  = r_sync2 ^ (^r_shift);
            w_state_nxt    = ST_STOP;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 4'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_tick_cnt == TICK_W'(OSR - 1)) begin
            w_tick_cnt_nxt = '0;
            w_state_nxt    = ST_IDLE;
            // Framing error outranks parity; either one discards the byte.
            if (!r_sync2) begin
              w_ferr = 1'b1;
`ifdef SM_UART_RX_PARITY_EN
            end else if (r_par_bad) begin
              w_perr = 1'b1;
`endif
            end else begin
              w_done = 1'b1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A completion coinciding with a transfer loads the new byte, no overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_ferr;
      overrun   <= 1'b0;
      if (w_done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end
      end else if (w_xfer) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SM_UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= w_perr;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sm_uart_rx.sv
// Directed self-checking bench for sm_uart_rx at 16 clocks per bit.
module tb_sm_uart_rx;

  localparam int unsigned CLK_FREQ  = 1_600_000;
  localparam int unsigned BAUD_RATE = 100_000;
`ifdef SM_UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  // rx drive -> 2 sync flops -> mid-stop sample -> registered valid
  localparam int unsigned LAT = NBITS * 16 - 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, parity_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned cyc = 0;
  int unsigned n_valid = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_xfer = 0;
  int unsigned last_rise = 0;
  logic        prev_v = 1'b0;
  logic [7:0]  xbytes [256];

  sm_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && !prev_v) last_rise = cyc;
      if (rx_valid) n_valid++;
      if (rx_valid && rx_ready) begin
        xbytes[n_xfer[7:0]] = rx_data;
        n_xfer++;
      end
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (parity_err) n_perr++;
    end
    prev_v = rx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_clk(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame: start, 8 data LSB first, optional parity, stop; then 16 idle clocks.
  // rst_bit pulses reset for one clock at the start of that frame bit index.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input int rst_bit, output int unsigned t0);
    logic [10:0] bits;
    bits = {stop_b, par_b, d, 1'b0};
    if (NBITS == 10) bits[9] = stop_b;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int i = 0; i < int'(NBITS); i++) begin
      rx = bits[i];
      if (i == rst_bit) begin
        rst = 1'b1;
        tick_clk(1);
        rst = 1'b0;
        tick_clk(15);
      end else begin
        tick_clk(16);
      end
    end
    rx = 1'b1;
    tick_clk(16);
  endtask

  int unsigned t0;
  int unsigned b_v, b_x, b_f, b_o, b_p;

  task automatic snap();
    b_v = n_valid; b_x = n_xfer; b_f = n_ferr; b_o = n_ovr; b_p = n_perr;
  endtask

  initial begin : wd
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick_clk(3);
    check_eq("rst_data",   {24'd0, rx_data}, 32'h00);
    check_eq("rst_valid",  {31'd0, rx_valid}, 32'd0);
    check_eq("rst_flags",  {29'd0, frame_err, overrun, parity_err}, 32'd0);
    rst = 1'b0;
    tick_clk(5);

    // 0xA5 with consumer ready
    rx_ready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 1'b0, -1, t0);
    check_eq("a5_latency", last_rise - t0, LAT);
    check_eq("a5_vcycles", n_valid - b_v, 32'd1);
    check_eq("a5_nxfer",   n_xfer - b_x, 32'd1);
    check_eq("a5_data",    {24'd0, xbytes[b_x[7:0]]}, 32'hA5);
    check_eq("a5_ferr",    n_ferr - b_f, 32'd0);
    check_eq("a5_ovr",     n_ovr - b_o, 32'd0);
    check_eq("a5_perr",    n_perr - b_p, 32'd0);

    // Overrun: 0x3C held while 0x81 arrives
    rx_ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, -1, t0);
    send_frame(8'h81, 1'b1, 1'b0, -1, t0);
    check_eq("ovr_valid",  {31'd0, rx_valid}, 32'd1);
    check_eq("ovr_data",   {24'd0, rx_data}, 32'h3C);
    check_eq("ovr_pulses", n_ovr - b_o, 32'd1);
    check_eq("ovr_nxfer0", n_xfer - b_x, 32'd0);
    rx_ready = 1'b1;
    tick_clk(1);
    rx_ready = 1'b0;
    check_eq("ovr_nxfer1", n_xfer - b_x, 32'd1);
    check_eq("ovr_xdata",  {24'd0, xbytes[b_x[7:0]]}, 32'h3C);
    check_eq("ovr_vclr",   {31'd0, rx_valid}, 32'd0);

    // Framing error then recovery
    rx_ready = 1'b1;
    snap();
    send_frame(8'h55, 1'b0, 1'b0, -1, t0);
    check_eq("fe_pulses",  n_ferr - b_f, 32'd1);
    check_eq("fe_vcycles", n_valid - b_v, 32'd0);
    check_eq("fe_valid",   {31'd0, rx_valid}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b0, -1, t0);
    check_eq("fe_nxfer",   n_xfer - b_x, 32'd1);
    check_eq("fe_data",    {24'd0, xbytes[b_x[7:0]]}, 32'h12);
    check_eq("fe_ferr2",   n_ferr - b_f, 32'd1);

    // 5-clock glitch is rejected
    snap();
    rx = 1'b0;
    tick_clk(5);
    rx = 1'b1;
    tick_clk(200);
    check_eq("gl_vcycles", n_valid - b_v, 32'd0);
    check_eq("gl_flags",   (n_ferr - b_f) + (n_ovr - b_o) + (n_perr - b_p), 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0, -1, t0);
    check_eq("gl_after",   {24'd0, xbytes[b_x[7:0]]}, 32'h7E);

    // Reset in data bit 4 of 0xFF, then 0x0F
    snap();
    send_frame(8'hFF, 1'b1, 1'b0, 5, t0);
    check_eq("rs_data",    {24'd0, rx_data}, 32'h00);
    check_eq("rs_nxfer",   n_xfer - b_x, 32'd0);
    check_eq("rs_ferr",    n_ferr - b_f, 32'd0);
    send_frame(8'h0F, 1'b1, 1'b0, -1, t0);
    check_eq("rs_nxfer1",  n_xfer - b_x, 32'd1);
    check_eq("rs_xdata",   {24'd0, xbytes[b_x[7:0]]}, 32'h0F);
`ifdef SM_UART_RX_PARITY_EN
    send_frame(8'h0F, 1'b1, 1'b1, -1, t0);
    check_eq("pe_pulses",  n_perr - b_p, 32'd1);
    check_eq("pe_nxfer",   n_xfer - b_x, 32'd1);
    check_eq("pe_ferr",    n_ferr - b_f, 32'd0);
`else
    check_eq("np_perr",    n_perr - b_p, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
